// File: rtl/mem_mgr_if.sv
// Byte command/response link between the memory manager and its upstream byte transceiver.
interface mem_mgr_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/mem_mgr.sv
// Owns the core run/halt state; while halted it loads/peeks memory and dumps registers over a byte link.
// Manager outputs are registered (LOAD write 1 cycle after handshake, READ reply 3 cycles); tx holds until accepted.
module mem_mgr #(
  parameter int MABL = 19
) (
  input  logic            clk,
  input  logic            rst,
  mem_mgr_if.slave        link,
  output logic            state,
  input  logic            cede,
  input  logic            core_we,
  input  logic [7:0]      core_wd,
  input  logic [MABL-1:0] core_ad,
  output logic [7:0]      core_rd,
  output logic            mem_we,
  output logic [7:0]      mem_wd,
  output logic [MABL-1:0] mem_ad,
  input  logic [7:0]      mem_rd,
  output logic [4:0]      memmgr_ra1,
  input  logic [31:0]     rf_rd1
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_LOAD, S_ADDR, S_RDWAIT, S_RUN, S_DUMP, S_TX, S_ACK
  } fsm_t;

  localparam logic [MABL-1:0] PTR_ONE = MABL'(1);

  fsm_t            fsm_q, fsm_d;
  logic            run_q, run_d;
  logic            tx_vld_q, tx_vld_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            we_q, we_d;
  logic [7:0]      wd_q, wd_d;
  logic [MABL-1:0] ad_q, ad_d;
  logic [MABL-1:0] ptr_q, ptr_d;
  logic [4:0]      ra_q, ra_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [23:0]     sh_q, sh_d;
  logic [23:0]     rem_q, rem_d;
  logic [23:0]     word_q, word_d;
  logic            rd_ph_q, rd_ph_d;
  logic            dumping_q, dumping_d;

  logic            rx_fire;
  logic            tx_fire;
  logic [23:0]     sh_nxt;

  assign rx_fire = link.rx_valid & link.rx_ready;
  assign tx_fire = tx_vld_q & link.tx_ready;
  assign sh_nxt  = {sh_q[15:0], link.rx_data};

  assign link.rx_ready = (fsm_q == S_IDLE) || (fsm_q == S_LEN) ||
                         (fsm_q == S_ADDR) || (fsm_q == S_LOAD);
  assign link.tx_valid = tx_vld_q;
  assign link.tx_data  = tx_dat_q;

  assign state      = run_q;
  assign memmgr_ra1 = ra_q;
  assign core_rd    = mem_rd;
  // Mux follows the registered run bit, so it switches in the same cycle state does.
  assign mem_we = run_q ? core_we : we_q;
  assign mem_wd = run_q ? core_wd : wd_q;
  assign mem_ad = run_q ? core_ad : ad_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      run_q     <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_dat_q  <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      ad_q      <= '0;
      ptr_q     <= '0;
      ra_q      <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rem_q     <= '0;
      word_q    <= '0;
      rd_ph_q   <= 1'b0;
      dumping_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      run_q     <= run_d;
      tx_vld_q  <= tx_vld_d;
      tx_dat_q  <= tx_dat_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      ad_q      <= ad_d;
      ptr_q     <= ptr_d;
      ra_q      <= ra_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      word_q    <= word_d;
      rd_ph_q   <= rd_ph_d;
      dumping_q <= dumping_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    run_d     = run_q;
    tx_vld_d  = tx_vld_q;
    tx_dat_d  = tx_dat_q;
    we_d      = 1'b0;
    wd_d      = wd_q;
    ad_d      = ad_q;
    ptr_d     = ptr_q;
    ra_d      = ra_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rem_d     = rem_q;
    word_d    = word_q;
    rd_ph_d   = rd_ph_q;
    dumping_d = dumping_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          case (link.rx_data)
            8'h01: fsm_d = S_LEN;
            8'h02: begin
              fsm_d = S_RUN;
              run_d = 1'b1;
            end
            8'h03: begin
              fsm_d     = S_DUMP;
              ra_d      = 5'd0;
              dumping_d = 1'b1;
            end
            8'h04: fsm_d = S_ADDR;
            default: begin
              fsm_d    = S_ACK;
              tx_vld_d = 1'b1;
              tx_dat_d = 8'h3F;
            end
          endcase
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          sh_d  = sh_nxt;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            ptr_d = '0;
            rem_d = sh_nxt;
            if (sh_nxt == 24'd0) begin
              fsm_d    = S_ACK;
              tx_vld_d = 1'b1;
              tx_dat_d = 8'h4B;
            end else begin
              fsm_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (rx_fire) begin
          we_d  = 1'b1;
          ad_d  = ptr_q;
          wd_d  = link.rx_data;
          ptr_d = ptr_q + PTR_ONE;
          rem_d = rem_q - 24'd1;
          if (rem_q == 24'd1) begin
            fsm_d    = S_ACK;
            tx_vld_d = 1'b1;
            tx_dat_d = 8'h4B;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          sh_d  = sh_nxt;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            ad_d      = sh_nxt[MABL-1:0];
            rd_ph_d   = 1'b0;
            dumping_d = 1'b0;
            fsm_d     = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        // First cycle presents the address, second captures the synchronous read data.
        if (!rd_ph_q) begin
          rd_ph_d = 1'b1;
        end else begin
          tx_dat_d = mem_rd;
          tx_vld_d = 1'b1;
          fsm_d    = S_TX;
        end
      end
      S_RUN: begin
        if (cede) begin
          run_d    = 1'b0;
          tx_dat_d = 8'h48;
          fsm_d    = S_ACK;
        end
      end
      S_DUMP: begin
        word_d   = rf_rd1[31:8];
        tx_dat_d = rf_rd1[7:0];
        tx_vld_d = 1'b1;
        cnt_d    = 2'd0;
        fsm_d    = S_TX;
      end
      S_TX: begin
        if (tx_fire) begin
          if (!dumping_q) begin
            tx_vld_d = 1'b0;
            fsm_d    = S_IDLE;
          end else if (cnt_q != 2'd3) begin
            cnt_d    = cnt_q + 2'd1;
            tx_dat_d = word_q[7:0];
            word_d   = {8'h00, word_q[23:8]};
          end else if (ra_q == 5'd31) begin
            dumping_d = 1'b0;
            tx_dat_d  = 8'h4B;
            fsm_d     = S_ACK;
          end else begin
            ra_d     = ra_q + 5'd1;
            tx_vld_d = 1'b0;
            fsm_d    = S_DUMP;
          end
        end
      end
      S_ACK: begin
        // Entered from RUN with valid low: the halt ack is presented one cycle after state falls.
        if (!tx_vld_q) begin
          tx_vld_d = 1'b1;
        end else if (tx_fire) begin
          tx_vld_d = 1'b0;
          fsm_d    = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_mgr.sv
// Scoreboarded bench for mem_mgr: a driver issues commands and queues expected bytes/writes, monitors pop and compare.
module tb_mem_mgr;
  localparam int MABL = 19;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            state;
  logic            cede;
  logic            core_we;
  logic [7:0]      core_wd;
  logic [MABL-1:0] core_ad;
  logic [7:0]      core_rd;
  logic            mem_we;
  logic [7:0]      mem_wd;
  logic [MABL-1:0] mem_ad;
  logic [7:0]      mem_rd;
  logic [4:0]      memmgr_ra1;
  logic [31:0]     rf_rd1;

  always #5 clk = ~clk;

  mem_mgr_if bus ();

  mem_mgr #(.MABL(MABL)) dut (
    .clk(clk), .rst(rst), .link(bus), .state(state), .cede(cede),
    .core_we(core_we), .core_wd(core_wd), .core_ad(core_ad), .core_rd(core_rd),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_ad(mem_ad), .mem_rd(mem_rd),
    .memmgr_ra1(memmgr_ra1), .rf_rd1(rf_rd1)
  );

  // Environment: synchronous byte memory and a combinational register file.
  logic [7:0]  mem [0:(1<<MABL)-1];
  logic [31:0] rf  [0:31];
  always @(posedge clk) begin
    if (mem_we) mem[mem_ad] <= mem_wd;
    mem_rd <= mem[mem_ad];
  end
  assign rf_rd1 = rf[memmgr_ra1];

  typedef struct packed {
    logic [MABL-1:0] ad;
    logic [7:0]      wd;
    logic [31:0]     cyc;
  } wr_t;

  logic [7:0] txq[$];
  wr_t        wq[$];
  logic [7:0] ref_mem [int];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  last_tx_cyc = 0;
  bit  rnd_rdy = 1'b0;
  bit  gaps = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: tx byte stream and memory write port.
  logic       pend = 1'b0;
  logic [7:0] pend_dat = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(pend_dat));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (txq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected: got byte %02h, expected no byte (cycle %0d)", bus.tx_data, cyc);
        end else begin
          chk("tx_byte", 32'(bus.tx_data), 32'(txq.pop_front()));
        end
        last_tx_cyc = cyc;
      end
      pend     = bus.tx_valid && !bus.tx_ready;
      pend_dat = bus.tx_data;
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got write %0h<=%02h, expected none (cycle %0d)", mem_ad, mem_wd, cyc);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_ad), 32'(w.ad));
          chk("wr_data", 32'(mem_wd), 32'(w.wd));
          chk("wr_cycle", 32'(cyc), w.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller must be just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, output int hs);
    int n;
    hs = -1;
    n = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (n) step();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int k = 0; k < 100 && hs < 0; k++) begin
      @(negedge clk);
      if (bus.rx_ready) hs = cyc;
      step();
    end
    bus.rx_valid = 1'b0;
    if (hs < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_timeout: byte %02h not accepted, expected accept", b);
    end
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] v, output int hs);
    send_byte(op, hs);
    send_byte(v[23:16], hs);
    send_byte(v[15:8], hs);
    send_byte(v[7:0], hs);
  endtask

  task automatic send_data(input logic [7:0] d[$]);
    int hs;
    foreach (d[i]) begin
      wr_t w;
      send_byte(d[i], hs);
      w.ad  = MABL'(i);
      w.wd  = d[i];
      w.cyc = 32'(hs + 1);
      wq.push_back(w);
      ref_mem[i] = d[i];
    end
  endtask

  task automatic do_load(input logic [7:0] d[$]);
    int hs;
    txq.push_back(8'h4B);
    send_hdr(8'h01, 24'(d.size()), hs);
    send_data(d);
  endtask

  task automatic do_read(input int addr, output int hs);
    txq.push_back(ref_mem[addr]);
    send_hdr(8'h04, 24'(addr), hs);
  endtask

  task automatic expect_dump();
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) txq.push_back(rf[r][8*b +: 8]);
    txq.push_back(8'h4B);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (txq.size() == 0 && wq.size() == 0 && !bus.tx_valid) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(txq.size() + wq.size()), 32'd0);
    step();
  endtask

  task automatic core_write(input logic [MABL-1:0] a, input logic [7:0] d);
    wr_t w;
    core_we = 1'b1;
    core_ad = a;
    core_wd = d;
    w.ad = a;
    w.wd = d;
    w.cyc = 32'(cyc);
    wq.push_back(w);
    ref_mem[int'(a)] = d;
    @(negedge clk);
    chk("run_mem_we", 32'(mem_we), 32'd1);
    chk("run_mem_ad", 32'(mem_ad), 32'(a));
    step();
    core_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    logic [7:0] d[$];
    logic [7:0] x, y;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    cede = 1'b0;
    core_we = 1'b0;
    core_wd = 8'h00;
    core_ad = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[5] = 32'h12345678;

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wd", 32'(mem_wd), 32'd0);
    chk("rst_mem_ad", 32'(mem_ad), 32'd0);
    chk("rst_ra1", 32'(memmgr_ra1), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Directed load then read-back with latency measurement.
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(d);
    wait_drain(50);
    do_read(2, hs);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_valid) break;
    end
    chk("read_latency", 32'(cyc), 32'(hs + 3));
    wait_drain(50);

    // Register dump with random backpressure, then with tx_ready tied high for timing.
    rnd_rdy = 1'b1;
    expect_dump();
    send_byte(8'h03, hs);
    wait_drain(2000);
    rnd_rdy = 1'b0;
    step();
    expect_dump();
    send_byte(8'h03, hs);
    wait_drain(400);
    chk("dump_cycles", 32'(last_tx_cyc), 32'(hs + 161));

    // Run, core writes pass through, cede halts.
    send_byte(8'h02, hs);
    @(negedge clk);
    chk("run_state_rise", 32'(state), 32'd1);
    chk("run_rise_cycle", 32'(cyc), 32'(hs + 1));
    step();
    core_write(MABL'(32'h10), 8'h55);
    for (int i = 0; i < 3; i++) core_write(MABL'(32'h20 + i), 8'($urandom));
    @(negedge clk);
    chk("core_rd_follow", 32'(core_rd), 32'(mem_rd));
    step();
    txq.push_back(8'h48);
    cede = 1'b1;
    @(negedge clk);
    chk("cede_state_hold", 32'(state), 32'd1);
    step();
    cede = 1'b0;
    @(negedge clk);
    chk("cede_state_fall", 32'(state), 32'd0);
    chk("cede_tx_low", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    chk("cede_tx_rise", 32'(bus.tx_valid), 32'd1);
    step();
    wait_drain(50);
    do_read(16, hs);
    wait_drain(50);
    do_read(33, hs);
    wait_drain(50);

    // cede while idle has no effect; bad opcodes and an empty load.
    cede = 1'b1;
    step();
    cede = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_cede_ignored", 32'(state), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      x = (i == 0) ? 8'h07 : (i == 1) ? 8'h00 : 8'($urandom_range(5, 255));
      txq.push_back(8'h3F);
      send_byte(x, hs);
      wait_drain(50);
    end
    d = {};
    do_load(d);
    wait_drain(50);

    // Randomized loads and reads with rx gaps and tx backpressure.
    gaps = 1'b1;
    rnd_rdy = 1'b1;
    for (int it = 0; it < 6; it++) begin
      int n;
      n = int'($urandom_range(1, 12));
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      do_load(d);
      wait_drain(200);
      for (int r = 0; r < 3; r++) begin
        do_read(int'($urandom_range(0, n - 1)), hs);
        wait_drain(200);
      end
    end
    gaps = 1'b0;
    rnd_rdy = 1'b0;
    step();

    // Reset in the middle of a load after two data bytes.
    send_hdr(8'h01, 24'd8, hs);
    x = 8'($urandom);
    y = 8'($urandom);
    d = '{x, y};
    send_data(d);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_rx_ready", 32'(bus.rx_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    do_read(1, hs);
    wait_drain(50);
    do_read(0, hs);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
